// File: rtl/sm_adder_scheduler.sv
// Round-robin scheduler sharing one pipelined sign-magnitude adder between two requesters.
// One operation in flight; the result returns tagged with its ID, an overflow flag and -0 cleared.
module sm_adder_scheduler #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADD_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    input  logic [DATA_WIDTH-1:0] add_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_sum,
    output logic                  rsp_id,
    output logic                  rsp_ovf,
    output logic                  busy
);
    localparam int unsigned MagW = DATA_WIDTH - 1;
    localparam int unsigned CntW = $clog2(ADD_LAT + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(ADD_LAT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic                  ptr_q;
    logic [CntW-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0] add_a_q, add_b_q, sum_q;
    logic                  id_q, ovf_q;

    logic                  grant, xfer, ovf_d;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;
    logic [MagW:0]         mag_sum;

    // Arbitration and operand selection; a transfer happens whenever IDLE sees any valid.
    always_comb begin
        grant   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        sel_a   = grant ? req1_a : req0_a;
        sel_b   = grant ? req1_b : req0_b;
        mag_sum = {1'b0, sel_a[MagW-1:0]} + {1'b0, sel_b[MagW-1:0]};
        ovf_d   = (sel_a[MagW] == sel_b[MagW]) && mag_sum[MagW];
        xfer    = (state_q == StIdle) && (req0_valid || req1_valid) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (xfer) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = xfer && !grant;
        req1_ready = xfer && grant;
        busy       = (state_q != StIdle);
        rsp_valid  = (state_q == StResp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (xfer) begin
                add_a_q <= sel_a;
                add_b_q <= sel_b;
                id_q    <= grant;
                ovf_q   <= ovf_d;
                ptr_q   <= ~grant;
                cnt_q   <= CntInit;
            end
            if (state_q == StWait) begin
                if (cnt_q == '0) begin
                    // A zero magnitude is always reported as +0.
                    sum_q <= (add_sum[MagW-1:0] == '0) ? '0 : add_sum;
                end else begin
                    cnt_q <= cnt_q - CntOne;
                end
            end
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign rsp_sum = sum_q;
    assign rsp_id  = id_q;
    assign rsp_ovf = ovf_q;

endmodule
